// File: rtl/can_timing_pkg.sv
// Shared types for the CAN timing event capture path: record layout, default widths, output FSM states.
package can_timing_pkg;

  localparam int TS_W_DEF   = 32;
  localparam int NUM_CH_DEF = 4;
  localparam int CH_W_DEF   = $clog2(NUM_CH_DEF);

  typedef struct packed {
    logic [CH_W_DEF-1:0] ch;
    logic [TS_W_DEF-1:0] ts;
  } evt_rec_t;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'b01,
    OUT_FULL  = 2'b10
  } out_state_t;

endpackage

// File: rtl/event_edge_latch.sv
// One event channel: rising-edge detect, timestamp slot, pending flag and sticky overflow.
// A grant in the same cycle as a new edge frees the slot, so the new edge refills it without overflow.
module event_edge_latch #(
  parameter int TS_W = 32
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            enable,
  input  logic            evt,
  input  logic [TS_W-1:0] ts_cnt,
  input  logic            grant,
  input  logic            clear_ovf,
  output logic            pending,
  output logic            overflow,
  output logic [TS_W-1:0] slot_ts
);

  logic prev;
  logic cap;

  // prev tracks the level even while disabled, so re-enabling never fakes an edge
  assign cap = evt & ~prev & enable;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev     <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
      slot_ts  <= '0;
    end else begin
      prev <= evt;
      if (cap & (grant | ~pending)) begin
        slot_ts <= ts_cnt;
        pending <= 1'b1;
      end else if (grant) begin
        pending <= 1'b0;
      end
      overflow <= (cap & pending & ~grant) | (overflow & ~clear_ovf);
    end
  end

endmodule

// File: rtl/event_timestamp_arbiter.sv
// Timestamps rising edges on NUM_CH event lines and serialises them round-robin onto one valid/ready port.
// Edge to out_valid is two cycles on an idle path; out_valid holds its record until accepted.
module event_timestamp_arbiter
  import can_timing_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int TS_W   = TS_W_DEF
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         evt_in,
  input  logic                      out_ready,
  input  logic                      clear_ovf,
  output logic                      out_valid,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [TS_W-1:0]           out_ts,
  output logic [NUM_CH-1:0]         overflow,
  output logic                      busy
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [TS_W-1:0]   ts_cnt;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] grant;
  logic [TS_W-1:0]   slot_ts [NUM_CH];
  logic [CH_W-1:0]   rr;
  logic [CH_W-1:0]   gnt_idx;
  logic              load;
  out_state_t        state;

  // First requester strictly after the last winner, wrapping around
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last) + k) % NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
    return pick;
  endfunction

  assign gnt_idx = rr_pick(pending, rr);
  assign load    = (|pending) & ((state == OUT_EMPTY) | out_ready);
  assign grant   = load ? (NUM_CH'(1) << gnt_idx) : '0;
  assign busy    = (|pending) | out_valid;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ts_cnt <= '0;
    end else if (enable) begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    event_edge_latch #(.TS_W(TS_W)) u_latch (
      .clk       (clk),
      .resetN    (resetN),
      .enable    (enable),
      .evt       (evt_in[i]),
      .ts_cnt    (ts_cnt),
      .grant     (grant[i]),
      .clear_ovf (clear_ovf),
      .pending   (pending[i]),
      .overflow  (overflow[i]),
      .slot_ts   (slot_ts[i])
    );
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= OUT_EMPTY;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_ts    <= '0;
      rr        <= CH_W'(NUM_CH - 1);
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (load) begin
            state     <= OUT_FULL;
            out_valid <= 1'b1;
          end
        end
        OUT_FULL: begin
          if (out_ready && !load) begin
            state     <= OUT_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= OUT_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
      if (load) begin
        out_ch <= gnt_idx;
        out_ts <= slot_ts[gnt_idx];
        rr     <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_event_timestamp_arbiter.sv
// Directed scenarios plus random traffic, every cycle compared against a spec-level reference model.
module tb_event_timestamp_arbiter;
  localparam int N  = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          enable = 1'b0;
  logic          out_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic [N-1:0]  evt_in = '0;
  logic          out_valid;
  logic [1:0]    out_ch;
  logic [TW-1:0] out_ts;
  logic [N-1:0]  overflow;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_ts;
  bit m_prev [N];
  bit m_pend [N];
  bit m_ovf  [N];
  int m_pts  [N];
  bit m_vld;
  int m_ch, m_ots, m_rr;

  event_timestamp_arbiter #(.NUM_CH(N), .TS_W(TW)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .enable    (enable),
    .evt_in    (evt_in),
    .out_ready (out_ready),
    .clear_ovf (clear_ovf),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ts    (out_ts),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_vld = 0; m_ch = 0; m_ots = 0; m_rr = N - 1;
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0; m_pts[i] = 0;
    end
  endtask

  // One clock of the specified behaviour: output stage hands off / grabs the next
  // round-robin record first, then this cycle's edges land in the (possibly freed) slots.
  task automatic model_step();
    int  g;
    int  idx;
    bit  e;
    bit  setovf;
    g = -1;
    if (!m_vld || out_ready) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && m_pend[idx]) g = idx;
      end
      if (g >= 0) begin
        m_vld = 1; m_ch = g; m_ots = m_pts[g]; m_rr = g; m_pend[g] = 0;
      end else begin
        m_vld = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      e = evt_in[i] && !m_prev[i] && enable;
      m_prev[i] = evt_in[i];
      setovf = e && m_pend[i];
      if (e && !m_pend[i]) begin
        m_pts[i] = m_ts; m_pend[i] = 1;
      end
      if (setovf) m_ovf[i] = 1;
      else if (clear_ovf) m_ovf[i] = 0;
    end
    if (enable) m_ts = (m_ts + 1) % (1 << TW);
  endtask

  task automatic compare();
    logic [N-1:0] ov;
    bit           bz;
    bz = m_vld;
    for (int i = 0; i < N; i++) begin
      ov[i] = m_ovf[i];
      if (m_pend[i]) bz = 1;
    end
    check("out_valid", 32'(out_valid), 32'(m_vld));
    if (m_vld) begin
      check("out_ch", 32'(out_ch), 32'(m_ch));
      check("out_ts", 32'(out_ts), 32'(m_ots));
    end
    check("overflow", 32'(overflow), 32'(ov));
    check("busy", 32'(busy), 32'(bz));
  endtask

  task automatic step();
    @(posedge clk);
    if (!resetN) model_reset();
    else model_step();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int t4x;

  initial begin
    model_reset();
    run(2);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_ts", 32'(out_ts), 32'd0);

    // single edge on ch2 at ts=10
    resetN = 1'b1; enable = 1'b1; out_ready = 1'b1;
    run(10);
    evt_in = 4'b0100;
    step();
    step();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_ch", 32'(out_ch), 32'd2);
    check("t1_ts", 32'(out_ts), 32'd10);
    step();
    check("t1_busy", 32'(busy), 32'd0);

    // fairness: all channels together, twice
    evt_in = '0; step();
    evt_in = 4'hF; run(6);
    evt_in = '0; step();
    evt_in = 4'hF; run(6);

    // backpressure
    evt_in = '0; out_ready = 1'b0; step();
    evt_in = 4'b1010; run(20);
    out_ready = 1'b1; run(5);

    // overflow: ch0 occupies the output, ch1 stays pending and sees a second edge
    evt_in = '0; out_ready = 1'b0; step();
    evt_in = 4'b0001; run(2);
    t4x = m_ts;
    evt_in = 4'b0011; step();
    evt_in = 4'b0001; step();
    evt_in = 4'b0011; step();
    check("t4_ovf", 32'(overflow[1]), 32'd1);
    out_ready = 1'b1; step();
    check("t4_ch", 32'(out_ch), 32'd1);
    check("t4_ts", 32'(out_ts), 32'(t4x));
    clear_ovf = 1'b1; step();
    clear_ovf = 1'b0;
    check("t4_clr", 32'(overflow), 32'd0);
    run(3);

    // timestamp wrap: ch0 at 255, ch1 at 0
    evt_in = '0; step();
    for (int k = 0; k < 300 && m_ts != 255; k++) step();
    evt_in = 4'b0001; step();
    evt_in = 4'b0011; step();
    check("t5_wrap_hi", 32'(out_ts), 32'd255);
    step();
    check("t5_wrap_lo", 32'(out_ts), 32'd0);
    run(2);

    // disabled edge, then re-enable with level still high
    enable = 1'b0; evt_in = 4'b1000; run(4);
    enable = 1'b1; run(4);
    check("t5_noedge", 32'(busy), 32'd0);

    // async reset while FULL with three pending
    evt_in = '0; out_ready = 1'b0; step();
    evt_in = 4'hF; run(2);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_ch", 32'(out_ch), 32'd0);
    check("t6_ts", 32'(out_ts), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    evt_in = '0; run(2);
    resetN = 1'b1; out_ready = 1'b1; run(5);

    // random traffic
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) evt_in[i] = ~evt_in[i];
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      clear_ovf = ($urandom_range(0, 15) == 0);
      step();
    end
    clear_ovf = 1'b0; out_ready = 1'b1; run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
